// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative round sequencer.
// Holds the sequencer state enum, block width, round counts per key size,
// the forward S-box and the byte-level round transforms used by
// one_round and final_round. Blocks use FIPS-197 byte order: byte 0 in
// [127:120], and byte i belongs to row i%4, column i/4.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [AES_BLK_W-1:0] blk_t;

    typedef enum logic [2:0] {
        IDLE,
        WHITEN,
        RND_A,
        RND_B,
        FIN_A,
        FIN_B,
        DONE
    } seq_state_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic blk_t sub_bytes(input blk_t b);
        blk_t r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[8*i +: 8] = SBOX[b[8*i +: 8]];
        end
        return r;
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic blk_t shift_rows(input blk_t b);
        blk_t r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = b[127 - 8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic blk_t mix_columns(input blk_t b);
        blk_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = b[127 - 32*c -: 8];
            a1 = b[119 - 32*c -: 8];
            a2 = b[111 - 32*c -: 8];
            a3 = b[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake and key-store bus of the AES round sequencer.
//   in_valid/in_ready/in_data     plaintext input handshake
//   out_valid/out_ready/out_data  ciphertext output handshake
//   rk_addr/rk_data               round-key store read (1-cycle latency)
//   busy                          engine is processing a block
// Modports:
//   slave  - the sequencer side
//   master - the client side (plaintext source, ciphertext sink, key store)
interface aes_round_sequencer_if #(
    parameter int RK_ADDR_W = 4
);

    logic                          in_valid;
    logic                          in_ready;
    logic [aes_pkg::AES_BLK_W-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [aes_pkg::AES_BLK_W-1:0] out_data;
    logic [RK_ADDR_W-1:0]          rk_addr;
    logic [aes_pkg::AES_BLK_W-1:0] rk_data;
    logic                          busy;

    modport slave (
        input  in_valid, in_data, out_ready, rk_data,
        output in_ready, out_valid, out_data, rk_addr, busy
    );

    modport master (
        output in_valid, in_data, out_ready, rk_data,
        input  in_ready, out_valid, out_data, rk_addr, busy
    );

endinterface

// File: rtl/final_round.sv
// Last AES round (SubBytes, ShiftRows, AddRoundKey; no MixColumns) with the
// same two-cycle timing as one_round: registered S-box lookup, then
// combinational ShiftRows and key XOR.
//   clk        clock for the lookup register
//   state_in   round input, sampled at the rising edge
//   key        final round key, applied combinationally in the following cycle
//   state_out  ciphertext, valid the cycle after state_in was presented
module final_round
    import aes_pkg::*;
(
    input  logic clk,
    input  blk_t state_in,
    input  blk_t key,
    output blk_t state_out
);

    blk_t sb_q;

    always_ff @(posedge clk) begin
        sb_q <= sub_bytes(state_in);
    end

    assign state_out = shift_rows(sb_q) ^ key;

endmodule

// File: rtl/one_round.sv
// One full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) split
// over two cycles: the S-box lookup is registered on every clock edge and the
// remaining linear steps plus the key XOR are combinational from that register.
//   clk        clock for the lookup register
//   state_in   round input, sampled at the rising edge
//   key        round key, applied combinationally in the following cycle
//   state_out  round output, valid the cycle after state_in was presented
module one_round
    import aes_pkg::*;
(
    input  logic clk,
    input  blk_t state_in,
    input  blk_t key,
    output blk_t state_out
);

    blk_t sb_q;

    always_ff @(posedge clk) begin
        sb_q <= sub_bytes(state_in);
    end

    assign state_out = mix_columns(shift_rows(sb_q)) ^ key;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller. Accepts one plaintext block, applies
// the initial AddRoundKey, runs NR-1 passes through a shared one_round, one
// pass through final_round, and presents the ciphertext until it is taken.
// Round keys come from an external store with a 1-cycle synchronous read.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   slave view of aes_round_sequencer_if:
//         in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//         rk_addr (registered key index), rk_data (key for last cycle's
//         rk_addr), busy (high from WHITEN through FIN_B)
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR        = NR_AES128,
    parameter int RK_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_round_sequencer_if.slave   bus
);

    localparam logic [RK_ADDR_W-1:0] LAST_ROUND = RK_ADDR_W'(NR);

    seq_state_t           state_q, state_d;
    logic [RK_ADDR_W-1:0] round_q, round_d;
    logic [RK_ADDR_W-1:0] rk_addr_q, rk_addr_d;
    logic [RK_ADDR_W-1:0] round_inc;
    blk_t                 state_reg_q, state_reg_d;
    blk_t                 rnd_out;
    blk_t                 fin_out;

    assign round_inc = round_q + 1'b1;

    one_round u_one_round (
        .clk       (clk),
        .state_in  (state_reg_q),
        .key       (bus.rk_data),
        .state_out (rnd_out)
    );

    final_round u_final_round (
        .clk       (clk),
        .state_in  (state_reg_q),
        .key       (bus.rk_data),
        .state_out (fin_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            round_q     <= '0;
            rk_addr_q   <= '0;
            state_reg_q <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            rk_addr_q   <= rk_addr_d;
            state_reg_q <= state_reg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        rk_addr_d   = rk_addr_q;
        state_reg_d = state_reg_q;

        case (state_q)
            IDLE: begin
                // The plaintext is parked in state_reg until whitening.
                if (bus.in_valid) begin
                    state_reg_d = bus.in_data;
                    rk_addr_d   = '0;
                    state_d     = WHITEN;
                end
            end
            WHITEN: begin
                state_reg_d = state_reg_q ^ bus.rk_data;
                rk_addr_d   = RK_ADDR_W'(1);
                round_d     = RK_ADDR_W'(1);
                state_d     = RND_A;
            end
            RND_A: begin
                state_d = RND_B;
            end
            RND_B: begin
                state_reg_d = rnd_out;
                rk_addr_d   = round_inc;
                round_d     = round_inc;
                state_d     = (round_inc == LAST_ROUND) ? FIN_A : RND_A;
            end
            FIN_A: begin
                state_d = FIN_B;
            end
            FIN_B: begin
                state_reg_d = fin_out;
                state_d     = DONE;
            end
            DONE: begin
                // Key index returns to 0 here so the store already presents
                // key 0 when the next block reaches WHITEN.
                if (bus.out_ready) begin
                    rk_addr_d = '0;
                    round_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = state_reg_q;
    assign bus.rk_addr   = rk_addr_q;
    assign bus.busy      = (state_q == WHITEN) || (state_q == RND_A) || (state_q == RND_B) ||
                           (state_q == FIN_A)  || (state_q == FIN_B);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer (AES-128, NR=10). The reference
// model computes the S-box from GF(2^8) inversion, expands keys and encrypts
// whole blocks; the bench also acts as the synchronous round-key store.
module tb_aes_round_sequencer;

    localparam int NR        = 10;
    localparam int RK_ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_round_sequencer_if #(.RK_ADDR_W(RK_ADDR_W)) bus ();

    aes_round_sequencer #(
        .NR        (NR),
        .RK_ADDR_W (RK_ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] rk_mem [0:10];
    logic [7:0]   sbox_t [256];

    always @(posedge clk) begin
        bus.rk_data <= (bus.rk_addr <= 4'd10) ? rk_mem[bus.rk_addr] : '0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // S-box = affine transform of the multiplicative inverse (x^254).
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp  = {tmp[23:0], tmp[31:24]};
                tmp  = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                       ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] blk;
        blk = pt ^ rk_mem[0];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127 - 8*i -: 8]];
            for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
            if (r < NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gf_mul(8'h02, a0) ^ gf_mul(8'h03, a1) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gf_mul(8'h02, a1) ^ gf_mul(8'h03, a2) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gf_mul(8'h02, a2) ^ gf_mul(8'h03, a3);
                    t[4*c+3] = gf_mul(8'h03, a0) ^ a1 ^ a2 ^ gf_mul(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = t[i];
            blk ^= rk_mem[r];
        end
        return blk;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge (DUT in WHITEN).
    task automatic send(input string tag, input logic [127:0] pt);
        int n;
        n = 0;
        bus.in_data  = pt;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check_eq($sformatf("%s_accept", tag), bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = rand128();
    endtask

    task automatic recv(input string tag, input logic [127:0] exp, input int stall, input int exp_lat);
        int           lat;
        logic         ok;
        logic [127:0] held;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        check_eq($sformatf("%s_lat", tag), lat, exp_lat);
        check_eq($sformatf("%s_data", tag), bus.out_data, exp);
        held = bus.out_data;
        ok   = 1'b1;
        for (int i = 0; i < stall; i++) begin
            step();
            if (!(bus.out_valid && bus.out_data === held && !bus.in_ready && !bus.busy)) ok = 1'b0;
        end
        if (stall > 0) check_eq($sformatf("%s_hold", tag), ok, 1'b1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq($sformatf("%s_idle", tag), {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pt, exp;
        logic [127:0] pts  [4];
        logic [127:0] exps [4];
        int           idx, got, guard, last, extra, exp_a;
        logic         acc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {bus.in_ready, bus.out_valid, bus.busy, bus.rk_addr}, {3'b100, 4'd0});
        rst = 1'b0;
        step();

        // FIPS-197 Appendix B vector
        set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        send("appb", 128'h3243f6a8885a308d313198a2e0370734);
        recv("appb", 128'h3925841d02dc09fbdc118597196a0b32, 0, 21);

        // FIPS-197 C.1 vector with key-index trace
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        send("c1", 128'h00112233445566778899aabbccddeeff);
        for (int k = 0; k < 21; k++) begin
            exp_a = (k == 0) ? 0 : (((k + 1) / 2 > NR) ? NR : (k + 1) / 2);
            check_eq($sformatf("c1_rk_addr_%0d", k), {bus.busy, bus.rk_addr}, {1'b1, 4'(exp_a)});
            step();
        end
        recv("c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0);

        // Backpressure: 50 cycles with out_ready low
        pt = rand128();
        send("bp", pt);
        recv("bp", aes_ref(pt), 50, 21);

        // Back-to-back: in_valid and out_ready held high
        set_key(rand128());
        for (int i = 0; i < 4; i++) begin
            pts[i]  = rand128();
            exps[i] = aes_ref(pts[i]);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = pts[0];
        idx = 0; got = 0; guard = 0; last = 0;
        while (got < 4 && guard < 400) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check_eq($sformatf("b2b_data_%0d", got), bus.out_data, exps[got]);
                if (got > 0) check_eq($sformatf("b2b_gap_%0d", got), guard - last, 23);
                last = guard;
                got++;
            end
            step();
            guard++;
            if (acc) begin
                idx++;
                if (idx < 4) bus.in_data = pts[idx];
                else         bus.in_valid = 1'b0;
            end
        end
        check_eq("b2b_count", got, 4);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid || !bus.in_ready) extra++;
            step();
        end
        check_eq("b2b_no_extra", extra, 0);
        bus.out_ready = 1'b0;

        // Reset while rk_addr==5, then a clean block
        pt = rand128();
        send("rst", pt);
        guard = 0;
        while (bus.rk_addr != 4'd5 && guard < 50) begin
            step();
            guard++;
        end
        check_eq("rst_reached_5", bus.rk_addr, 4'd5);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_outputs", {bus.out_valid, bus.busy, bus.in_ready, bus.rk_addr}, {3'b001, 4'd0});
        @(negedge clk);
        rst = 1'b0;
        step();
        pt = rand128();
        send("post_rst", pt);
        recv("post_rst", aes_ref(pt), 2, 21);

        // in_valid pulses while busy are ignored
        pt  = rand128();
        exp = aes_ref(pt);
        send("pulse", pt);
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = rand128();
            step();
        end
        bus.in_valid = 1'b0;
        recv("pulse", exp, 0, 15);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid || bus.busy) extra++;
            step();
        end
        check_eq("pulse_no_extra", extra, 0);

        // Random keys, plaintexts and output stalls
        for (int b = 0; b < 5; b++) begin
            set_key(rand128());
            pt = rand128();
            send($sformatf("rnd%0d", b), pt);
            recv($sformatf("rnd%0d", b), aes_ref(pt), int'($urandom_range(0, 6)), 21);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
